// File: rtl/if_id_skid_reg.sv
//==============================================================================
// Module      : if_id_skid_reg
// Description : Fetch-to-decode pipeline register backed by a 2-entry skid
//               buffer; optional stall-cycle counter under IF_ID_STALL_CNT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module if_id_skid_reg #(
    parameter int                    PC_WIDTH   = 64,
    parameter int                    INST_WIDTH = 32,
    parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_valid,
    output logic                  if_ready,
    input  logic [PC_WIDTH-1:0]   if_pc,
    input  logic [INST_WIDTH-1:0] if_inst,
    input  logic                  flush_i,
    input  logic                  stall_i,
    output logic                  id_valid,
    output logic [PC_WIDTH-1:0]   id_pc,
    output logic [INST_WIDTH-1:0] id_inst,
    output logic [31:0]           stall_cycles
);

    localparam logic [1:0] c_FULL = 2'd2;

    logic [PC_WIDTH-1:0]   r_pc   [2];
    logic [INST_WIDTH-1:0] r_inst [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;

    logic w_ready;
    logic w_valid;
    logic w_push;
    logic w_pop;

    // Handshake derives from registered count only, keeping stall_i off the fetch path.
    assign w_ready = (r_count != c_FULL);
    assign w_valid = (r_count != 2'd0);
    assign w_push  = if_valid & w_ready & ~flush_i;
    assign w_pop   = w_valid & ~stall_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else if (flush_i) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b11: begin
                    r_wr_ptr <= ~r_wr_ptr;
                    r_rd_ptr <= ~r_rd_ptr;
                end
                2'b10: begin
                    r_wr_ptr <= ~r_wr_ptr;
                    r_count  <= r_count + 2'd1;
                end
                2'b01: begin
                    r_rd_ptr <= ~r_rd_ptr;
                    r_count  <= r_count - 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Payload storage needs no reset: it is only observed while count marks it valid.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_pc[r_wr_ptr]   <= if_pc;
            r_inst[r_wr_ptr] <= if_inst;
        end
    end

    assign if_ready = w_ready;
    assign id_valid = w_valid;
    assign id_pc    = w_valid ? r_pc[r_rd_ptr]   : '0;
    assign id_inst  = w_valid ? r_inst[r_rd_ptr] : NOP_INST;

`ifdef IF_ID_STALL_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= 32'd0;
        end else if (w_valid && stall_i && !flush_i) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_id_skid_reg.sv
//==============================================================================
// Module      : tb_if_id_skid_reg
// Description : Self-checking bench for if_id_skid_reg (directed + random).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_if_id_skid_reg;

    localparam int          PC_W   = 64;
    localparam int          INST_W = 32;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clk;
    logic              rst_n;
    logic              if_valid;
    logic              if_ready;
    logic [PC_W-1:0]   if_pc;
    logic [INST_W-1:0] if_inst;
    logic              flush_i;
    logic              stall_i;
    logic              id_valid;
    logic [PC_W-1:0]   id_pc;
    logic [INST_W-1:0] id_inst;
    logic [31:0]       stall_cycles;

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO of {pc, inst} capped at two entries.
    logic [PC_W+INST_W-1:0] q[$];
    logic [31:0]            m_stall;

    if_id_skid_reg #(
        .PC_WIDTH  (PC_W),
        .INST_WIDTH(INST_W),
        .NOP_INST  (NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .flush_i     (flush_i),
        .stall_i     (stall_i),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        bit m_valid;
        bit m_ready;
        m_valid = (q.size() != 0);
        m_ready = (q.size() < 2);
        if (!rst_n) begin
            q.delete();
            m_stall = 32'd0;
        end else begin
`ifdef IF_ID_STALL_CNT_EN
            if (m_valid && stall_i && !flush_i) m_stall = m_stall + 32'd1;
`endif
            if (flush_i) begin
                q.delete();
            end else begin
                if (m_valid && !stall_i) void'(q.pop_front());
                if (if_valid && m_ready) q.push_back({if_pc, if_inst});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [PC_W-1:0] pc, input bit st, input bit fl);
        if_valid = v;
        if_pc    = pc;
        if_inst  = pc[31:0] ^ 32'h5A5A_0000;
        stall_i  = st;
        flush_i  = fl;
    endtask

    task automatic drain();
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
        checks++; if (id_pc !== '0) begin failures++; $display("FAIL reset_pc got=%h exp=0", id_pc); end
        checks++; if (id_inst !== NOP) begin failures++; $display("FAIL reset_inst got=%h exp=%h", id_inst, NOP); end
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", if_ready); end
        checks++; if (stall_cycles !== 32'd0) begin failures++; $display("FAIL reset_stallcnt got=%0d exp=0", stall_cycles); end
    endtask

    task automatic test_stream();
        logic [PC_W-1:0] pc;
        for (int i = 0; i < 3; i++) begin
            pc = 64'h8000_0000 + 64'(4 * i);
            drive(1'b1, pc, 1'b0, 1'b0);
            tick();
            checks++; if (id_pc !== pc || id_valid !== 1'b1) begin
                failures++; $display("FAIL stream_pc%0d got=%h/%b exp=%h/1", i, id_pc, id_valid, pc);
            end
            checks++; if (id_inst !== (pc[31:0] ^ 32'h5A5A_0000)) begin
                failures++; $display("FAIL stream_inst%0d got=%h exp=%h", i, id_inst, pc[31:0] ^ 32'h5A5A_0000);
            end
            checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL stream_ready%0d got=%b exp=1", i, if_ready); end
        end
        drain();
    endtask

    task automatic test_stall_fill();
        drive(1'b1, 64'h8000_0010, 1'b1, 1'b0);
        tick();
        drive(1'b1, 64'h8000_0014, 1'b1, 1'b0);
        tick();
        checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", if_ready); end
        checks++; if (id_pc !== 64'h8000_0010) begin failures++; $display("FAIL full_head got=%h exp=80000010", id_pc); end
        drive(1'b1, 64'h8000_0018, 1'b1, 1'b0);
        tick();
        checks++; if (id_pc !== 64'h8000_0010 || if_ready !== 1'b0) begin
            failures++; $display("FAIL full_ignore got=%h/%b exp=80000010/0", id_pc, if_ready);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        checks++; if (id_pc !== 64'h8000_0014) begin failures++; $display("FAIL drain_second got=%h exp=80000014", id_pc); end
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL drain_ready got=%b exp=1", if_ready); end
        tick();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", id_valid); end
    endtask

    task automatic test_flush();
        drive(1'b1, 64'h8000_0018, 1'b1, 1'b0);
        tick();
        drive(1'b1, 64'h8000_001C, 1'b1, 1'b0);
        tick();
        drive(1'b1, 64'h8000_0020, 1'b1, 1'b1);
        tick();
        checks++; if (id_valid !== 1'b0 || id_pc !== '0) begin
            failures++; $display("FAIL flush_out got=%b/%h exp=0/0", id_valid, id_pc);
        end
        checks++; if (id_inst !== NOP || if_ready !== 1'b1) begin
            failures++; $display("FAIL flush_bubble got=%h/%b exp=%h/1", id_inst, if_ready, NOP);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL flush_dropped got=%b exp=0", id_valid); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 64'h8000_0030, 1'b1, 1'b0);
        tick();
        drive(1'b1, 64'h8000_0034, 1'b1, 1'b0);
        tick();
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        checks++; if (id_valid !== 1'b0 || id_pc !== '0 || id_inst !== NOP) begin
            failures++; $display("FAIL rstmid_out got=%b/%h/%h exp=0/0/%h", id_valid, id_pc, id_inst, NOP);
        end
        checks++; if (if_ready !== 1'b1 || stall_cycles !== 32'd0) begin
            failures++; $display("FAIL rstmid_ready got=%b/%0d exp=1/0", if_ready, stall_cycles);
        end
        tick();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rstmid_empty got=%b exp=0", id_valid); end
    endtask

    task automatic test_stall_cnt();
        logic [31:0] exp_cnt;
`ifdef IF_ID_STALL_CNT_EN
        exp_cnt = 32'd5;
`else
        exp_cnt = 32'd0;
`endif
        drive(1'b1, 64'h8000_0040, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        checks++; if (stall_cycles !== exp_cnt) begin
            failures++; $display("FAIL stallcnt got=%0d exp=%0d", stall_cycles, exp_cnt);
        end
        checks++; if (id_pc !== 64'h8000_0040) begin failures++; $display("FAIL stallcnt_hold got=%h exp=80000040", id_pc); end
        drain();
    endtask

    task automatic test_random();
        logic [PC_W+INST_W-1:0] head;
        logic [PC_W-1:0]        e_pc;
        logic [INST_W-1:0]      e_inst;
        for (int n = 0; n < 600; n++) begin
            if_valid = ($urandom_range(0, 3) != 0);
            if_pc    = {32'h0, 32'h8000_0000 + ($urandom & 32'h0000_FFFC)};
            if_inst  = $urandom;
            stall_i  = ($urandom_range(0, 2) == 0);
            flush_i  = ($urandom_range(0, 15) == 0);
            rst_n    = ($urandom_range(0, 99) != 0);
            tick();
            rst_n = 1'b1;
            if (q.size() != 0) begin
                head   = q[0];
                e_pc   = head[PC_W+INST_W-1:INST_W];
                e_inst = head[INST_W-1:0];
            end else begin
                e_pc   = '0;
                e_inst = NOP;
            end
            checks++; if (id_valid !== (q.size() != 0)) begin
                failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", n, id_valid, q.size() != 0);
            end
            checks++; if (if_ready !== (q.size() < 2)) begin
                failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", n, if_ready, q.size() < 2);
            end
            checks++; if (id_pc !== e_pc || id_inst !== e_inst) begin
                failures++; $display("FAIL rnd_data cyc=%0d got=%h/%h exp=%h/%h", n, id_pc, id_inst, e_pc, e_inst);
            end
            checks++; if (stall_cycles !== m_stall) begin
                failures++; $display("FAIL rnd_stallcnt cyc=%0d got=%0d exp=%0d", n, stall_cycles, m_stall);
            end
        end
        drain();
    endtask

    initial begin
        m_stall = 32'd0;
        rst_n   = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        test_reset();
        test_stream();
        test_stall_fill();
        test_flush();
        test_reset_mid();
        test_stall_cnt();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
